// File: rtl/deb_multi_if.sv
// Bundle carrying the raw inputs, run-time controls and debounced outputs of deb_multi.
// The bench drives the master side; the debouncer sits on the slave side.
interface deb_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic             en;
  logic [CNT_W-1:0] thresh;
  logic [N_CH-1:0]  in;
  logic [N_CH-1:0]  out;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic             any_edge;

  modport master (
    output en, thresh, in,
    input  out, rise, fall, any_edge
  );

  modport slave (
    input  en, thresh, in,
    output out, rise, fall, any_edge
  );
endinterface

// File: rtl/deb_multi.sv
// Multi-channel debouncer: per-channel synchroniser, en-gated stability counter, registered level and edge strobes.
// With en high an input edge appears on out after SYNC_STAGES + thresh + 1 clk edges; no backpressure.
module deb_multi #(
  parameter int   N_CH        = 4,
  parameter int   CNT_W       = 16,
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  deb_multi_if.slave   bus
);

  logic [N_CH-1:0] out_q;
  logic [N_CH-1:0] out_nxt;
  logic [N_CH-1:0] rise_q;
  logic [N_CH-1:0] rise_nxt;
  logic [N_CH-1:0] fall_q;
  logic [N_CH-1:0] fall_nxt;
  logic            any_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   samp;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   out_d;
    logic                   rise_d;
    logic                   fall_d;

    if (SYNC_STAGES == 1) begin : g_sync1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
        else        sync_q <= bus.in[i];
      end
    end else begin : g_syncn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.in[i]};
      end
    end

    assign samp = sync_q[SYNC_STAGES-1];

    // >= lets a threshold lowered mid-count expire on the very next tick
    always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q[i];
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (samp == out_q[i]) begin
        cnt_d = '0;
      end else if (bus.en && (cnt_q >= bus.thresh)) begin
        cnt_d  = '0;
        out_d  = samp;
        rise_d = samp;
        fall_d = ~samp;
      end else if (bus.en) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign out_nxt[i]  = out_d;
    assign rise_nxt[i] = rise_d;
    assign fall_nxt[i] = fall_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= {N_CH{RST_VAL}};
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      out_q  <= out_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
      any_q  <= |(rise_nxt | fall_nxt);
    end
  end

  assign bus.out      = out_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.any_edge = any_q;

endmodule

// File: tb/tb_deb_multi.sv
// Directed bench for deb_multi: reset, latency, glitch rejection, enable gating, threshold change, independence.
module tb_deb_multi;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [3:0] rise_acc;
  logic [3:0] fall_acc;

  deb_multi_if #(.N_CH(4), .CNT_W(16)) bus ();

  deb_multi #(.N_CH(4), .CNT_W(16), .SYNC_STAGES(2), .RST_VAL(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clk edges, ending 1 time unit after the last edge; accumulate strobes seen.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rise_acc = rise_acc | bus.rise;
      fall_acc = fall_acc | bus.fall;
    end
  endtask

  initial begin
    rise_acc   = '0;
    fall_acc   = '0;
    rst_n      = 1'b0;
    bus.in     = 4'hF;
    bus.en     = 1'b1;
    bus.thresh = 16'd3;

    // reset holds everything cleared even with inputs high
    tick(3);
    chk("rst_out", 32'(bus.out), 32'h0);
    chk("rst_rise", 32'(bus.rise), 32'h0);
    chk("rst_any", 32'(bus.any_edge), 32'h0);
    chk("rst_cnt", 32'(dut.g_ch[0].cnt_q), 32'h0);

    rst_n = 1'b1;
    tick(5);
    chk("lat_out_e5", 32'(bus.out), 32'h0);
    tick(1);
    chk("lat_out_e6", 32'(bus.out), 32'hF);
    chk("lat_rise_e6", 32'(bus.rise), 32'hF);
    chk("lat_any_e6", 32'(bus.any_edge), 32'h1);
    chk("lat_fall_e6", 32'(bus.fall), 32'h0);
    tick(1);
    chk("lat_rise_e7", 32'(bus.rise), 32'h0);
    chk("lat_any_e7", 32'(bus.any_edge), 32'h0);

    // thresh 0: latency is SYNC_STAGES + 1
    bus.in     = 4'h0;
    bus.thresh = 16'd0;
    tick(2);
    chk("t0_out_e2", 32'(bus.out), 32'hF);
    tick(1);
    chk("t0_out_e3", 32'(bus.out), 32'h0);
    chk("t0_fall_e3", 32'(bus.fall), 32'hF);

    // glitch of 4 cycles with thresh 5 is rejected
    bus.thresh = 16'd5;
    rise_acc   = '0;
    bus.in     = 4'b0001;
    tick(4);
    bus.in     = 4'b0000;
    tick(10);
    chk("glitch_out", 32'(bus.out), 32'h0);
    chk("glitch_rise", 32'(rise_acc), 32'h0);

    // 6-cycle pulse is accepted at edge 8, released 8 edges after the fall
    bus.in = 4'b0001;
    tick(6);
    bus.in = 4'b0000;
    tick(1);
    chk("pulse_out_e7", 32'(bus.out), 32'h0);
    tick(1);
    chk("pulse_out_e8", 32'(bus.out), 32'h1);
    chk("pulse_rise_e8", 32'(bus.rise), 32'h1);
    tick(5);
    chk("pulse_out_e13", 32'(bus.out), 32'h1);
    chk("pulse_fall_e13", 32'(bus.fall), 32'h0);
    tick(1);
    chk("pulse_out_e14", 32'(bus.out), 32'h0);
    chk("pulse_fall_e14", 32'(bus.fall), 32'h1);

    // enable gating: thresh 2 needs 3 en ticks
    bus.thresh = 16'd2;
    bus.en     = 1'b0;
    bus.in     = 4'b0010;
    tick(3);
    bus.en = 1'b1; tick(1); bus.en = 1'b0; tick(9);
    chk("en_out_t1", 32'(bus.out), 32'h0);
    bus.en = 1'b1; tick(1); bus.en = 1'b0; tick(9);
    chk("en_out_t2", 32'(bus.out), 32'h0);
    chk("en_cnt_t2", 32'(dut.g_ch[1].cnt_q), 32'h2);
    bus.en = 1'b1; tick(1); bus.en = 1'b0;
    chk("en_out_t3", 32'(bus.out), 32'h2);
    chk("en_rise_t3", 32'(bus.rise), 32'h2);
    tick(1);
    chk("en_rise_after", 32'(bus.rise), 32'h0);

    // en held low through a mismatch freezes the channel
    bus.in = 4'b0000;
    tick(30);
    chk("frz_out", 32'(bus.out), 32'h2);
    chk("frz_cnt", 32'(dut.g_ch[1].cnt_q), 32'h0);
    bus.in = 4'b0010;
    tick(3);

    // threshold lowered mid-count expires on the next edge
    bus.en     = 1'b1;
    bus.thresh = 16'd100;
    bus.in     = 4'b0110;
    tick(20);
    chk("thr_out_before", 32'(bus.out), 32'h2);
    chk("thr_cnt_before", 32'(dut.g_ch[2].cnt_q), 32'd18);
    bus.thresh = 16'd10;
    tick(1);
    chk("thr_out_after", 32'(bus.out), 32'h6);
    chk("thr_rise", 32'(bus.rise), 32'h4);
    chk("thr_any", 32'(bus.any_edge), 32'h1);
    tick(1);
    chk("thr_rise_once", 32'(bus.rise), 32'h0);

    // alternating 3-cycle runs never reach a 5-tick window
    bus.thresh = 16'd4;
    rise_acc   = '0;
    fall_acc   = '0;
    for (int r = 0; r < 4; r++) begin
      bus.in = 4'b0101; tick(3);
      bus.in = 4'b1010; tick(3);
    end
    bus.in = 4'b0110;
    tick(6);
    chk("alt_out", 32'(bus.out), 32'h6);
    chk("alt_rise", 32'(rise_acc), 32'h0);
    chk("alt_fall", 32'(fall_acc), 32'h0);
    bus.in = 4'b1110;
    tick(6);
    chk("ch3_out_e6", 32'(bus.out), 32'h6);
    tick(1);
    chk("ch3_out_e7", 32'(bus.out), 32'hE);
    chk("ch3_rise_e7", 32'(bus.rise), 32'h8);

    // reset in mid-count restarts the full window
    bus.thresh = 16'd9;
    bus.in     = 4'hF;
    tick(9);
    chk("mid_cnt7", 32'(dut.g_ch[0].cnt_q), 32'd7);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_out", 32'(bus.out), 32'h0);
    chk("mid_rst_rise", 32'(bus.rise), 32'h0);
    chk("mid_rst_fall", 32'(bus.fall), 32'h0);
    chk("mid_rst_any", 32'(bus.any_edge), 32'h0);
    chk("mid_rst_cnt", 32'(dut.g_ch[0].cnt_q), 32'h0);
    rst_n    = 1'b1;
    rise_acc = '0;
    fall_acc = '0;
    tick(11);
    chk("mid_out_e11", 32'(bus.out), 32'h0);
    chk("mid_no_pulse", 32'(rise_acc | fall_acc), 32'h0);
    tick(1);
    chk("mid_out_e12", 32'(bus.out), 32'hF);
    chk("mid_rise_e12", 32'(bus.rise), 32'hF);

    // maximum threshold: counter climbs without expiring
    bus.thresh = 16'hFFFF;
    bus.in     = 4'h0;
    fall_acc   = '0;
    tick(50);
    chk("max_out", 32'(bus.out), 32'hF);
    chk("max_fall", 32'(fall_acc), 32'h0);
    chk("max_cnt", 32'(dut.g_ch[0].cnt_q), 32'd48);
    bus.thresh = 16'd0;
    tick(1);
    chk("max_drop_out", 32'(bus.out), 32'h0);
    chk("max_drop_fall", 32'(bus.fall), 32'hF);
    chk("max_drop_any", 32'(bus.any_edge), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
